video_rx_capture: RTL

- Receive side of the parallel video interface: accepts vin/hs/vs/de from a camera, decoder or test-pattern source.
- Aligns capture to frame boundaries and buffers active pixels in an on-chip FIFO for the frame-buffer write engine.
- Measures incoming timing (active size and totals).
- Counterpart of the timing generator that reads pixels out of the frame buffer. Single clock domain.

---
 rtl/video_pkg.sv | 26 ++
 rtl/video_rx_capture_if.sv | 35 +++
 rtl/video_rx_fifo.sv | 70 +++++++
 rtl/video_rx_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video receive/capture path.
//   - rx_state_t : capture FSM state encoding
//   - TIM_W      : width of every timing measurement counter
//   - POL_*      : sync polarity constants for HS_POL / VS_POL
//   - sat_inc    : saturating increment used by the timing counters
package video_pkg;

    localparam int TIM_W = 13;
    localparam logic [TIM_W-1:0] TIM_MAX = '1;

    localparam bit POL_ACTIVE_HIGH = 1'b1;
    localparam bit POL_ACTIVE_LOW  = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2
    } rx_state_t;

    // Counters stick at TIM_MAX instead of wrapping so an absent sync
    // reads as "very long" rather than as a bogus small value.
    function automatic logic [TIM_W-1:0] sat_inc(input logic [TIM_W-1:0] v);
        return (v == TIM_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/video_rx_capture_if.sv
// Video input bus plus capture-FIFO read port.
//   vin/hs_i/vs_i/de_i : parallel video from the source (master -> slave)
//   rd_en              : read request from the write engine (master -> slave)
//   rd_data            : FIFO read data (slave -> master)
//   rd_used            : FIFO fill count (slave -> master)
//   burst_ready        : rd_used has reached the burst threshold
// Read handshake: rd_en is a request, accepted only when rd_used != 0; the
// word of an accepted request appears on rd_data on the following cycle and
// holds until the next accepted request. A request while empty is a no-op.
interface video_rx_capture_if #(
    parameter int VID_WIDTH  = 16,
    parameter int FIFO_DEPTH = 512
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [VID_WIDTH-1:0] vin;
    logic                 hs_i;
    logic                 vs_i;
    logic                 de_i;
    logic                 rd_en;
    logic [VID_WIDTH-1:0] rd_data;
    logic [CNT_W-1:0]     rd_used;
    logic                 burst_ready;

    modport master (
        output vin, hs_i, vs_i, de_i, rd_en,
        input  rd_data, rd_used, burst_ready
    );

    modport slave (
        input  vin, hs_i, vs_i, de_i, rd_en,
        output rd_data, rd_used, burst_ready
    );

endinterface

// File: rtl/video_rx_fifo.sv
// Single-clock capture FIFO with synchronous flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO; a write in the same cycle lands at slot 0
//   wr_en      : write request (ignored when full, unless flushing)
//   wr_data    : write data
//   rd_en      : read request (ignored when empty or flushing)
//   rd_data    : registered read data, valid the cycle after an accepted read
//   full       : FIFO holds DEPTH words
//   used       : fill count, 0..DEPTH
module video_rx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   used
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             do_wr;
    logic             do_rd;
    logic [AW-1:0]    wr_addr;

    assign used  = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (used == (AW+1)'(DEPTH));

    // A flush frees the whole array, so a write alongside it is always
    // accepted; the read is dropped because its data belongs to the old frame.
    assign do_wr   = wr_en & (flush | ~full);
    assign do_rd   = rd_en & ~empty & ~flush;
    assign wr_addr = flush ? '0 : wr_ptr[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= {{AW{1'b0}}, do_wr};
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/video_rx_capture.sv
// Receive side of the parallel video interface.
// Registers the incoming video, aligns capture to vsync, buffers active
// pixels in a FIFO for the frame-buffer write engine and measures the
// incoming timing.
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   frame_en       : capture enable; low returns to IDLE and flushes the FIFO
//   vid            : video input bus and FIFO read port (slave side)
//   frame_start    : one-cycle pulse at each captured frame boundary
//   frame_done     : one-cycle pulse when a complete captured frame ended
//   h_active/v_active/h_total/v_total : timing of the last complete frame
//   meas_valid     : measurements hold a latched frame
//   fifo_overflow  : sticky, a pixel was dropped on a full FIFO this frame
//   dbg_state      : current FSM state
module video_rx_capture
    import video_pkg::*;
#(
    parameter int VID_WIDTH  = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_LEN  = 256,
    parameter bit HS_POL     = POL_ACTIVE_HIGH,
    parameter bit VS_POL     = POL_ACTIVE_HIGH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_en,
    video_rx_capture_if.slave vid,
    output logic              frame_start,
    output logic              frame_done,
    output logic [TIM_W-1:0]  h_active,
    output logic [TIM_W-1:0]  v_active,
    output logic [TIM_W-1:0]  h_total,
    output logic [TIM_W-1:0]  v_total,
    output logic              meas_valid,
    output logic              fifo_overflow,
    output rx_state_t         dbg_state
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_t state;

    // Input stage: one register, syncs normalised to active-high.
    logic [VID_WIDTH-1:0] vin_r;
    logic hs_r, vs_r, de_r;
    logic hs_d, vs_d, de_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vin_r <= '0;
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            de_r  <= 1'b0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
            de_d  <= 1'b0;
        end else begin
            vin_r <= vid.vin;
            hs_r  <= (vid.hs_i == HS_POL);
            vs_r  <= (vid.vs_i == VS_POL);
            de_r  <= vid.de_i;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
            de_d  <= de_r;
        end
    end

    logic hs_rise, vs_rise, de_rise, de_fall;
    assign hs_rise = hs_r & ~hs_d;
    assign vs_rise = vs_r & ~vs_d;
    assign de_rise = de_r & ~de_d;
    assign de_fall = ~de_r & de_d;

    // Frame events are ignored once frame_en drops, even before the FSM
    // has reached IDLE.
    logic frame_evt, cap_evt, flush, wr_req, wr_drop, fifo_full;
    assign frame_evt = vs_rise & frame_en & (state != IDLE);
    assign cap_evt   = vs_rise & frame_en & (state == CAPTURE);
    assign flush     = ~frame_en | frame_evt;
    assign wr_req    = de_r & frame_en & (state == CAPTURE);
    assign wr_drop   = wr_req & fifo_full & ~flush;

    video_rx_fifo #(
        .WIDTH (VID_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (wr_req),
        .wr_data (vin_r),
        .rd_en   (vid.rd_en),
        .rd_data (vid.rd_data),
        .full    (fifo_full),
        .used    (vid.rd_used)
    );

    assign vid.burst_ready = (vid.rd_used >= CNT_W'(BURST_LEN));
    assign dbg_state       = state;

    // Free-running timing counters; they run regardless of capture state
    // so the first latch after enabling already sees a whole frame.
    logic [TIM_W-1:0] h_cnt;     // de-high pixels in the current line
    logic [TIM_W-1:0] h_line;    // h_cnt of the last finished line
    logic [TIM_W-1:0] v_cnt;     // de_fall events since vs_rise
    logic [TIM_W-1:0] hclk_cnt;  // clocks since the last hs_rise
    logic [TIM_W-1:0] h_period;  // last complete hs period
    logic [TIM_W-1:0] hs_cnt;    // hs_rise events since vs_rise

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            h_line   <= '0;
            v_cnt    <= '0;
            hclk_cnt <= '0;
            h_period <= '0;
            hs_cnt   <= '0;
        end else begin
            if (de_r) begin
                h_cnt <= de_rise ? TIM_W'(1) : sat_inc(h_cnt);
            end
            if (de_fall) begin
                h_line <= h_cnt;
            end

            if (vs_rise) begin
                v_cnt <= '0;
            end else if (de_fall) begin
                v_cnt <= sat_inc(v_cnt);
            end

            if (hs_rise) begin
                h_period <= hclk_cnt;
                hclk_cnt <= TIM_W'(1);
            end else begin
                hclk_cnt <= sat_inc(hclk_cnt);
            end

            // An hs_rise coincident with vs_rise is the first line of the
            // new frame.
            if (vs_rise) begin
                hs_cnt <= hs_rise ? TIM_W'(1) : '0;
            end else if (hs_rise) begin
                hs_cnt <= sat_inc(hs_cnt);
            end
        end
    end

    // Capture FSM with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            h_active      <= '0;
            v_active      <= '0;
            h_total       <= '0;
            v_total       <= '0;
            meas_valid    <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            frame_start <= frame_evt;
            frame_done  <= cap_evt;

            if (!frame_en) begin
                state      <= IDLE;
                meas_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE:    state <= WAIT_VS;
                    WAIT_VS: if (vs_rise) state <= CAPTURE;
                    CAPTURE: state <= CAPTURE;
                    default: state <= IDLE;
                endcase
            end

            if (cap_evt) begin
                h_active   <= h_line;
                v_active   <= v_cnt;
                h_total    <= h_period;
                v_total    <= hs_cnt;
                meas_valid <= 1'b1;
            end

            if (flush) begin
                fifo_overflow <= 1'b0;
            end else if (wr_drop) begin
                fifo_overflow <= 1'b1;
            end
        end
    end

endmodule
